// File: rtl/counter_sched_pkg.sv
// counter_sched_pkg: shared types and helpers for the shared interval timer.
//   state_t  - scheduler FSM states (IDLE -> COUNT -> DONE -> IDLE)
//   PTR_W    - pointer width for the default requester count
//   ptr_w()  - pointer/index width for an arbitrary requester count
package counter_sched_pkg;

  localparam int N_REQ_DEF = 4;
  localparam int PTR_W     = $clog2(N_REQ_DEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A single requester still needs a 1-bit index.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick.
//   req     - request vector
//   ptr     - highest-priority requester index
//   win_oh  - one-hot winner (zero when no request)
//   win_idx - winner index (zero when no request)
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int PW    = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] win_oh,
  output logic [PW-1:0]    win_idx
);

  int   idx;
  logic found;

  // Scan from ptr upward with wrap; the first set request wins.
  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        win_oh[idx] = 1'b1;
        win_idx     = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// counter_sched: one down-counting interval timer shared round-robin among
// N_REQ requesters. The winner's len is loaded, counted to zero under grant,
// then a one-cycle done pulse is returned to the owner.
//   clk, rst - clock, async active-low reset
//   en       - count enable (0 holds the counter)
//   req      - level request per requester, held until done
//   len      - per-requester interval, slice i = len[i*CNT_W +: CNT_W]
//   gnt      - one-hot grant, decoded from registered state/owner
//   done     - one-cycle completion pulse to the owner
//   busy     - high in COUNT and DONE
//   count    - current counter value
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*CNT_W-1:0] len,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [CNT_W-1:0]       count
);

  localparam int PW = ptr_w(N_REQ);

  state_t           state, state_nxt;
  logic [PW-1:0]    owner, ptr, win_idx, owner_inc;
  logic [N_REQ-1:0] win_oh, owner_oh;
  logic             owner_req;

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_arb (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

  assign owner_req = req[owner];
  assign owner_inc = (owner == PW'(N_REQ - 1)) ? '0 : owner + PW'(1);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; an owner dropping req aborts straight to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|win_oh) state_nxt = COUNT;
      COUNT: begin
        if (!owner_req)                state_nxt = IDLE;
        else if (en && count == '0)    state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Counter, owner and rr pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: if (|win_oh) begin
          owner <= win_idx;
          count <= len[int'(win_idx)*CNT_W +: CNT_W];
        end
        COUNT: begin
          if (!owner_req) begin
            count <= '0;
            ptr   <= owner_inc;
          end else if (en && count != '0) begin
            count <= count - CNT_W'(1);
          end
        end
        DONE:    ptr <= owner_inc;
        default: ;
      endcase
    end
  end

  // Outputs decode from registered state and owner only.
  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
    gnt             = (state == COUNT) ? owner_oh : '0;
    done            = (state == DONE)  ? owner_oh : '0;
    busy            = (state != IDLE);
  end

endmodule
